// File: rtl/tpu_seq.sv
// Command sequencer for the DIM x DIM systolic MAC array: owns array timing for
// accumulator preload, matmul streaming and row readout.
module tpu_seq #(
  parameter int DIM = 8,
  parameter int AW  = $clog2(DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           buf_rd_en,
  output logic [AW-1:0]  buf_addr,
  output logic           skew_zero,
  output logic           mac_en,
  output logic [DIM-1:0] c_wr_en,
  output logic [AW-1:0]  c_row,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [2:0]     state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; cmd_ready and rd_valid depend only on registered state.

  localparam int KW = AW + 2;
  localparam logic [KW-1:0]  K_ROW_LAST  = KW'(DIM - 1);
  localparam logic [KW-1:0]  K_COMP_LAST = KW'(3 * DIM - 2);
  localparam logic [KW-1:0]  K_DIM       = KW'(DIM);
  localparam logic [KW-1:0]  K_ONE       = KW'(1);
  localparam logic [DIM-1:0] ROW0_MASK   = DIM'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADC   = 3'd1,
    S_COMPUTE = 3'd2,
    S_READ    = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t        state;
  logic [KW-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
    end else if (state != S_IDLE && abort) begin
      // Abort outranks the row handshake and the final-count transition.
      state <= S_IDLE;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            k <= '0;
            case (cmd_op)
              2'b00:   state <= S_LOADC;
              2'b01:   state <= S_COMPUTE;
              2'b10:   state <= S_READ;
              default: state <= S_ACK;
            endcase
          end
        end
        S_LOADC: begin
          if (k == K_ROW_LAST) begin
            state <= S_ACK;
            k     <= '0;
          end else begin
            k <= k + K_ONE;
          end
        end
        S_COMPUTE: begin
          if (k == K_COMP_LAST) begin
            state <= S_ACK;
            k     <= '0;
          end else begin
            k <= k + K_ONE;
          end
        end
        S_READ: begin
          if (rd_ready) begin
            if (k == K_ROW_LAST) begin
              state <= S_ACK;
              k     <= '0;
            end else begin
              k <= k + K_ONE;
            end
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          k     <= '0;
        end
        default: begin
          state <= S_IDLE;
          k     <= '0;
        end
      endcase
    end
  end

  // Pure decode of state and k; no input reaches an output combinationally.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    buf_rd_en = 1'b0;
    buf_addr  = '0;
    skew_zero = 1'b0;
    mac_en    = 1'b0;
    c_wr_en   = '0;
    c_row     = '0;
    rd_valid  = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_LOADC: begin
        c_wr_en = ROW0_MASK << k[AW-1:0];
        c_row   = k[AW-1:0];
      end
      S_COMPUTE: begin
        // Read data lands one cycle later, so MACs trail reads by one slot.
        buf_rd_en = (k < K_DIM);
        buf_addr  = (k < K_DIM) ? k[AW-1:0] : '0;
        mac_en    = (k != '0);
        skew_zero = (k > K_DIM);
      end
      S_READ: begin
        rd_valid = 1'b1;
        c_row    = k[AW-1:0];
      end
      S_ACK:   done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tpu_seq.sv
// Directed bench for tpu_seq at DIM=4: a per-command expected-output schedule
// is queued from the command rules and compared against the DUT every cycle.
module tb_tpu_seq;

  localparam int DIM = 4;
  localparam int AW  = 2;
  localparam int OW  = 9 + 2 * AW + DIM;

  localparam logic [1:0] OP_LOADC  = 2'b00;
  localparam logic [1:0] OP_MATMUL = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           cmd_valid, cmd_ready, abort, busy, done;
  logic [1:0]     cmd_op;
  logic           buf_rd_en, skew_zero, mac_en, rd_valid, rd_ready;
  logic [AW-1:0]  buf_addr, c_row;
  logic [DIM-1:0] c_wr_en;
  logic [2:0]     state_dbg;

  tpu_seq #(.DIM(DIM), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .abort(abort), .busy(busy), .done(done),
    .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .skew_zero(skew_zero),
    .mac_en(mac_en), .c_wr_en(c_wr_en), .c_row(c_row), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .state_dbg(state_dbg)
  );

  logic [OW-1:0] act_vec;
  assign act_vec = {cmd_ready, busy, done, buf_rd_en, buf_addr, skew_zero,
                    mac_en, c_wr_en, c_row, rd_valid};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc, done_cyc, done_cnt, acc_cnt;
  int mac_cnt, skew_cnt, bufrd_cnt, wr_cnt;
  logic [DIM-1:0] wr_or;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [OW-1:0] vec(input logic cr, input logic b, input logic d,
                                        input logic re, input logic [AW-1:0] a,
                                        input logic sk, input logic me,
                                        input logic [DIM-1:0] we,
                                        input logic [AW-1:0] row, input logic rv);
    return {cr, b, d, re, a, sk, me, we, row, rv};
  endfunction

  function automatic logic [OW-1:0] idle_vec();
    return vec(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endfunction

  function automatic logic [OW-1:0] ack_vec();
    return vec(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endfunction

  function automatic logic [OW-1:0] loadc_vec(input int i);
    logic [DIM-1:0] w;
    w = '0;
    w[i] = 1'b1;
    return vec(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, w, AW'(i), 1'b0);
  endfunction

  // Slot t reads operand t while it exists; the MAC consumes slot t-1.
  function automatic logic [OW-1:0] compute_vec(input int t);
    return vec(1'b0, 1'b1, 1'b0, t < DIM, (t < DIM) ? AW'(t) : '0,
               (t - 1) >= DIM, t >= 1, '0, '0, 1'b0);
  endfunction

  function automatic logic [OW-1:0] read_vec(input int row);
    return vec(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, AW'(row), 1'b1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare point, mid-cycle.
  always @(negedge clk) begin : cmp
    logic [OW-1:0] e;
    if (rst_n) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_vec();
      check($sformatf("out_cyc%0d", cyc), 64'(act_vec), 64'(e));
      if (cmd_valid && cmd_ready) begin
        accept_cyc = cyc;
        acc_cnt++;
        mac_cnt = 0; skew_cnt = 0; bufrd_cnt = 0; wr_cnt = 0; wr_or = '0;
      end
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (mac_en) mac_cnt++;
      if (skew_zero) skew_cnt++;
      if (buf_rd_en) bufrd_cnt++;
      if (c_wr_en != '0) wr_cnt++;
      wr_or |= c_wr_en;
    end
  end

  // ---------------- drivers ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_fixed(input logic [1:0] op);
    int n;
    start_cmd(op);
    if (op == OP_LOADC)
      for (int i = 0; i < DIM; i++) exp_q.push_back(loadc_vec(i));
    else if (op == OP_MATMUL)
      for (int t = 0; t < 3 * DIM - 1; t++) exp_q.push_back(compute_vec(t));
    exp_q.push_back(ack_vec());
    n = exp_q.size();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic [15:0] pat, input int plen);
    int row = 0;
    int c = 0;
    start_cmd(OP_READ);
    while (row < DIM && c < 200) begin
      rd_ready = (c < plen) ? pat[c] : 1'b1;
      exp_q.push_back(read_vec(row));
      if (rd_ready) row++;
      c++;
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    exp_q.push_back(ack_vec());
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, a0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; abort = 1'b0; rd_ready = 1'b0;
    accept_cyc = 0; done_cyc = 0; done_cnt = 0; acc_cnt = 0;
    mac_cnt = 0; skew_cnt = 0; bufrd_cnt = 0; wr_cnt = 0; wr_or = '0;

    repeat (2) @(posedge clk); #1;
    check("reset_outputs", 64'(act_vec), 64'(idle_vec()));
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    run_fixed(OP_LOADC);
    check("loadc_latency", 64'(done_cyc - accept_cyc), 64'd5);
    check("loadc_wr_cycles", 64'(wr_cnt), 64'd4);
    check("loadc_wr_rows", 64'(wr_or), 64'hF);
    check("loadc_mac", 64'(mac_cnt), 64'd0);

    run_fixed(OP_MATMUL);
    check("matmul_latency", 64'(done_cyc - accept_cyc), 64'd12);
    check("matmul_mac_cycles", 64'(mac_cnt), 64'd10);
    check("matmul_skew_cycles", 64'(skew_cnt), 64'd6);
    check("matmul_rd_cycles", 64'(bufrd_cnt), 64'd4);

    run_fixed(OP_NOP);
    check("nop_latency", 64'(done_cyc - accept_cyc), 64'd1);

    run_read(16'b111001, 6);
    check("read_bp_latency", 64'(done_cyc - accept_cyc), 64'd7);
    run_read(16'b1, 1);
    check("read_full_latency", 64'(done_cyc - accept_cyc), 64'd5);

    // abort while idle does nothing
    abort = 1'b1;
    repeat (2) @(posedge clk); #1;
    abort = 1'b0;

    // abort at COMPUTE k=6, then an immediate LOADC
    d0 = done_cnt;
    start_cmd(OP_MATMUL);
    for (int t = 0; t <= 6; t++) begin
      exp_q.push_back(compute_vec(t));
      if (t == 6) abort = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    run_fixed(OP_LOADC);
    check("post_abort_loadc_latency", 64'(done_cyc - accept_cyc), 64'd5);

    // abort beats the row handshake in READ
    d0 = done_cnt;
    start_cmd(OP_READ);
    rd_ready = 1'b1; abort = 1'b1;
    exp_q.push_back(read_vec(0));
    @(posedge clk); #1;
    rd_ready = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check("read_abort_no_done", 64'(done_cnt), 64'(d0));

    // cmd_valid held: MATMUL then NOP, nothing accepted while busy
    a0 = acc_cnt;
    cmd_valid = 1'b1; cmd_op = OP_MATMUL;
    @(posedge clk); #1;
    cmd_op = OP_NOP;
    for (int t = 0; t < 3 * DIM - 1; t++) exp_q.push_back(compute_vec(t));
    exp_q.push_back(ack_vec());
    exp_q.push_back(idle_vec());
    exp_q.push_back(ack_vec());
    repeat (13) @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_accepts", 64'(acc_cnt - a0), 64'd2);
    check("b2b_nop_latency", 64'(done_cyc - accept_cyc), 64'd1);

    // reset in the middle of LOADC drops strobes at once
    d0 = done_cnt;
    start_cmd(OP_LOADC);
    for (int i = 0; i < DIM; i++) exp_q.push_back(loadc_vec(i));
    exp_q.push_back(ack_vec());
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", 64'(act_vec), 64'(idle_vec()));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_no_done", 64'(done_cnt), 64'(d0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_seq.md
# tpu_seq

Sequencer for the DIM x DIM systolic array of signed MAC cells. It accepts one command at a time over a valid/ready handshake and drives the array-wide MAC enable, the per-row accumulator write enables, and the A/B operand buffer read address and skew-zero control. It also streams accumulator rows out to the host-side result path. It sits between the command front-end and the array/operand buffers and owns all array timing.

## Interface
- DIM, default 8: array dimension (rows = columns = K depth); 2..16.
- AW, default $clog2(DIM): width of row/address fields.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_op  in  2  00 LOADC, 01 MATMUL, 10 READ, 11 NOP
- abort  in  1  synchronous abort of the in-flight command
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on command completion
- buf_rd_en  out  1  operand buffer read strobe
- buf_addr  out  AW  operand buffer address (A column k / B row k)
- skew_zero  out  1  feed zeros into the edge skew registers this cycle
- mac_en  out  1  array-wide MAC enable (shift A/B, accumulate)
- c_wr_en  out  DIM  one-hot per-row accumulator write enable (loads Cin)
- c_row  out  AW  row index for LOADC and READ
- rd_valid  out  1  result row c_row presented
- rd_ready  in  1  result sink accepts row

## Operation
- States: IDLE, LOADC, COMPUTE, READ, ACK. A single counter k (width AW+2) is used in all non-IDLE states.
- All outputs are Moore decodes of the state and k registers, so no input is combinationally routed to an output.
- IDLE: cmd_ready=1. When cmd_valid is high, the command is accepted, k is cleared, and the next state follows cmd_op:
  - LOADC goes to LOADC.
  - MATMUL goes to COMPUTE.
  - READ goes to READ.
  - NOP goes to ACK.
- LOADC: DIM cycles. In cycle k, c_wr_en = 1<<k and c_row = k. After k = DIM-1, go to ACK.
- COMPUTE: 3*DIM-1 cycles, k = 0..3*DIM-2. The operand buffer has 1-cycle read latency.
  - buf_rd_en = (k < DIM) and buf_addr = k[AW-1:0]. When k >= DIM, buf_addr = 0.
  - mac_en = (k >= 1).
  - skew_zero = (k > DIM), meaning the data slot k-1 lies beyond the K depth.
  - c_wr_en = 0 throughout COMPUTE, so the accumulators are never written and enabled at the same time.
  - After k = 3*DIM-2, go to ACK.
- READ: rd_valid=1 and c_row=k.
  - k advances only on rd_valid & rd_ready. It holds indefinitely otherwise.
  - The handshake on row DIM-1 goes to ACK.
- ACK: one cycle with done=1, then IDLE. done is therefore high exactly 1 cycle after the last active cycle of any command.
- abort, from any non-IDLE state: next state is IDLE, k is cleared, and no done is issued. abort has no effect in IDLE. abort wins over the rd handshake and over the final-count transition in the same cycle.
- Outside its state, every strobe and enable is 0 and c_row = 0.

## Timing
- Reset (async, rst_n low): state = IDLE and k = 0.
  - While reset is asserted: cmd_ready=1, busy=0, done=0, buf_rd_en=0, buf_addr=0, skew_zero=0, mac_en=0, c_wr_en=0, c_row=0, rd_valid=0.
- Reset mid-command drops all strobes immediately (asynchronously). No done is issued.
- Accept to first active cycle: 1 cycle. The cycle after the cmd_valid & cmd_ready edge is k=0 of the new state.
- Command to done latency:
  - LOADC: DIM+1 cycles.
  - MATMUL: 3*DIM cycles.
  - NOP: 1 cycle.
  - READ: DIM+1 cycles with rd_ready held high; longer under backpressure.
- Back-to-back: a new command can be accepted no earlier than the cycle after done (IDLE). cmd_valid during busy is ignored, since cmd_ready=0.
- Reserved encodings: none remain, because 11 is defined as NOP.

## Test plan
- Reset, then release with DIM=4 → all outputs at reset values, cmd_ready=1. Hold cmd_valid=0 for 5 cycles → no output changes.
- LOADC at DIM=4 → c_wr_en = 0001, 0010, 0100, 1000 on 4 consecutive cycles with c_row = 0..3. done 5 cycles after accept. mac_en stays 0.
- MATMUL at DIM=4 → COMPUTE lasts 11 cycles.
  - buf_rd_en high for cycles 0-3 with buf_addr 0,1,2,3.
  - mac_en high for cycles 1-10 (10 cycles).
  - skew_zero high for cycles 5-10.
  - done 12 cycles after accept.
- READ at DIM=4 with rd_ready pattern 1,0,0,1,1,1 → rd_row sequence 0,1,1,1,2,3. done on the cycle after row 3 is accepted. busy=1 throughout.
- abort on COMPUTE k=6 → IDLE next cycle, mac_en=0, no done. A following LOADC is accepted immediately and completes normally.
- cmd_valid held high with alternating ops MATMUL, NOP → MATMUL done; cmd_ready rises one cycle later; NOP done 1 cycle after its accept. No command is accepted while busy=1.
